// File: rtl/sn74ls93_pkg.sv
// sn74ls93_pkg: shared widths and terminal-count value for the 74LS93 model.
package sn74ls93_pkg;
    localparam int CNT_W  = 4;
    localparam int SECB_W = 3;
    localparam logic [CNT_W-1:0] TC_VAL = 4'hF;
endpackage

// File: rtl/sn74ls93_div8.sv
// ls93_div8: section-B 3-bit counter, advances on clk falling edge when en_i, async active-low clear.
module ls93_div8
    import sn74ls93_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    output logic [SECB_W-1:0] q_o
);
    logic [SECB_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = en_i ? cnt_q + 1'b1 : cnt_q;

    always_ff @(negedge clk_i or negedge rst_n_i)
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign q_o = cnt_q;
endmodule

// File: rtl/sn74ls93.sv
// sn74ls93: 74LS93 4-bit ripple counter (div-2 + div-8) on clka falling edges, cleared by r0 == 11.
// Optional terminal-count output tc when SN74LS93_TC_EN is defined.
`timescale 1ns/100ps
module sn74ls93
    import sn74ls93_pkg::*;
(
    input  logic       clka,
    input  logic [1:0] r0,
    input  logic       clkb,
    output logic       qa,
    output logic       qb,
    output logic       qc,
    output logic       qd
`ifdef SN74LS93_TC_EN
    ,
    output logic       tc
`endif
);
    logic              rst_n;
    logic              qa_q, qa_d;
    logic [SECB_W-1:0] secb;

    // Only a definite 11 clears; X/Z on r0 leaves the counter running.
    assign rst_n = !(r0 === 2'b11);
    assign qa_d  = ~qa_q;

    always_ff @(negedge clka or negedge rst_n)
        if (!rst_n) qa_q <= 1'b0;
        else        qa_q <= qa_d;

    ls93_div8 u_div8 (
        .clk_i   (clka),
        .rst_n_i (rst_n),
        .en_i    (clkb),
        .q_o     (secb)
    );

    assign qa = qa_q;
    assign {qd, qc, qb} = secb;

`ifdef SN74LS93_TC_EN
    logic [CNT_W-1:0] cnt;
    assign cnt = {secb, qa_q};
    assign tc  = rst_n & (cnt == TC_VAL);
`endif
endmodule

// File: tb/tb_sn74ls93.sv
// tb_sn74ls93: directed self-checking bench for the 74LS93 counter model.
`timescale 1ns/100ps
module tb_sn74ls93;
    logic       clka;
    logic [1:0] r0;
    logic       clkb, clkb_drv, tie;
    logic       qa, qb, qc, qd;
`ifdef SN74LS93_TC_EN
    logic       tc;
`endif
    int n_chk = 0;
    int n_err = 0;

    assign clkb = tie ? qa : clkb_drv;

    sn74ls93 dut (
        .clka (clka),
        .r0   (r0),
        .clkb (clkb),
        .qa   (qa),
        .qb   (qb),
        .qc   (qc),
        .qd   (qd)
`ifdef SN74LS93_TC_EN
        ,
        .tc   (tc)
`endif
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic pulse();
        clka = 1'b1;
        #60;
        clka = 1'b0;
        #60;
    endtask

    function automatic logic [3:0] cnt();
        return {qd, qc, qb, qa};
    endfunction

    initial begin
        tie = 1'b1;
        clkb_drv = 1'b0;
        clka = 1'bx;
        r0 = 2'b11;
        #1 check("async_clear", cnt(), 4'b0000);
        clka = 1'b0;
        #60;
        pulse();
        check("clear_holds_edge", cnt(), 4'b0000);
        r0 = 2'b00;
        #60 check("release_holds", cnt(), 4'b0000);
        for (int i = 1; i <= 20; i++) begin
            pulse();
            if (i == 1)  check("edge1", cnt(), 4'b0001);
            if (i == 2)  check("edge2", cnt(), 4'b0010);
            if (i == 15) check("edge15", cnt(), 4'b1111);
            if (i == 16) check("edge16_wrap", cnt(), 4'b0000);
            if (i == 20) check("edge20", cnt(), 4'b0100);
`ifdef SN74LS93_TC_EN
            if (i == 15) check("tc_at_15", {3'b0, tc}, 4'd1);
            if (i == 16) check("tc_after_wrap", {3'b0, tc}, 4'd0);
`endif
        end
        clka = 1'b1;
        #30 check("rise_no_effect", cnt(), 4'b0100);
        clka = 1'b0;
        #60;
        check("fall_after_rise", cnt(), 4'b0101);
        r0 = 2'b01;
        pulse();
        check("r0_01_counts", cnt(), 4'b0110);
        r0 = 2'b10;
        pulse();
        check("r0_10_counts", cnt(), 4'b0111);
        r0 = 2'b00;
        repeat (4) pulse();
        check("at_1011", cnt(), 4'b1011);
        r0 = 2'b11;
        #10 check("mid_clear", cnt(), 4'b0000);
`ifdef SN74LS93_TC_EN
        check("tc_in_clear", {3'b0, tc}, 4'd0);
`endif
        pulse();
        check("clear_overrides", cnt(), 4'b0000);
        r0 = 2'b00;
        pulse();
        check("release_edge1", cnt(), 4'b0001);
        r0 = 2'b11;
        #10 r0 = 2'b00;
        tie = 1'b0;
        clkb_drv = 1'b0;
        pulse(); check("b_hold_1", cnt(), 4'b0001);
        pulse(); check("b_hold_2", cnt(), 4'b0000);
        pulse(); check("b_hold_3", cnt(), 4'b0001);
        pulse(); check("b_hold_4", cnt(), 4'b0000);
        clkb_drv = 1'b1;
        pulse(); check("b_inc_1", cnt(), 4'b0011);
        pulse(); check("b_inc_2", cnt(), 4'b0100);
        pulse(); check("b_inc_3", cnt(), 4'b0111);
        pulse(); check("b_inc_4", cnt(), 4'b1000);
        pulse(); check("b_inc_5", cnt(), 4'b1011);
        pulse(); check("b_inc_6", cnt(), 4'b1100);
        pulse(); check("b_inc_7", cnt(), 4'b1111);
        pulse(); check("b_inc_8_wrap", cnt(), 4'b0000);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sn74ls93.md
Name: sn74ls93

Overview:
- Behavioural model of the 74LS93 4-bit binary ripple counter, for the simulatable TTL model library.
- Section A is a divide-by-2 stage (qa). Section B is a divide-by-8 stage (qd qc qb).
- Board-level use ties clkb to qa, giving a divide-by-16 counter with dcba = qd qc qb qa.
- The block is modelled in a single clock domain (clka) with a gated-clear reset derived from r0.

Parameters:
- None. The model is fixed at 1 + 3 bits. Timescale is 1ns/100ps.

Ports:
- clka  input  1  single clock; all state changes on its falling edge (1->0).
- r0  input  2  reset gate pair. Internal clear rst_n = ~(r0[1] & r0[0]). rst_n is asynchronous and active-low, so the clear is asserted only when both r0 bits are 1.
- clkb  input  1  section-B advance input, sampled on the falling edge of clka (tied to qa for divide-by-16).
- qa  output  1  section A count bit (bit 0).
- qb  output  1  section B bit 0 (count bit 1).
- qc  output  1  section B bit 1 (count bit 2).
- qd  output  1  section B bit 2 (count bit 3, MSB).

Behaviour:
- Reset value: while rst_n = 0 (r0 = 2'b11), qa = qb = qc = qd = 0.
  - The clear is asynchronous: it takes effect immediately, with no clka edge required.
  - The clear overrides all clka edges.
  - r0 = 00, 01 or 10 does not clear.
- Reset release: when rst_n goes 1, the count holds 0000 until the next clka falling edge.
- clka rising edges: no effect.
- clka falling edge, with rst_n = 1:
  - qa toggles.
  - If clkb = 1 at that edge (value before the edge's updates), {qd,qc,qb} increments modulo 8.
  - If clkb = 0, {qd,qc,qb} holds.
- With clkb = qa:
  - The outputs form a 4-bit up-counter advancing one per clka falling edge: 0000, 0001, ..., 1111, 0000.
  - Wrap-around 1111 -> 0000 occurs on the 16th edge, with no extra flag.
- Section B wraps 111 -> 000 independently of qa.
- X or Z on clka:
  - State changes only on a clean 1->0 transition.
  - An x->0 transition counts as a falling edge; the first edge after power-up behaves this way.
- X/Z on r0:
  - Clear is asserted only on a definite 11.
  - Otherwise treat it as not cleared.
- Before any reset or edge, outputs are X. No built-in power-on value.
- Latency: outputs update in the same timestep as the clka falling edge, with zero modelled propagation delay.

Optional Feature:
- Macro SN74LS93_TC_EN.
- When defined, add output port tc (1 bit), combinational: tc = qa & qb & qc & qd, high only at count 1111. It is forced 0 while rst_n = 0.
- When undefined, port tc does not exist and there is no related logic. Counting behaviour is identical either way.

Decomposition:
- Shared package sn74ls93_pkg:
  - localparam CNT_W = 4
  - localparam SECB_W = 3
  - localparam TC_VAL = 4'hF
- Sub-module ls93_div8 (3-bit counter with enable and async active-low clear) is natural.
  - Section A is a single toggle flop in the top.
  - The top instantiates ls93_div8 for qb/qc/qd.

Test Plan:
- Async clear: clka = x, r0 = 11 -> qd qc qb qa = 0000 immediately. Then clka 0->1->0 with r0 = 11 -> remains 0000.
- Release and count: r0 = 00, clkb = qa, 20 clka pulses (0->1->0, 60 ns per phase):
  - After edges 1, 2, 15 the count is 0001, 0010, 1111.
  - Edge 16 gives 0000.
  - After edge 20 the count is 0100.
- Partial reset: r0 = 01 or 10 during counting -> counting continues, no clear.
- Mid-count clear: at count 1011, set r0 = 11 between edges -> 0000 at once. Release and 1 edge -> 0001.
- Section independence: clkb held 0, 4 clka edges from 0000 -> qa toggles 1,0,1,0 and qd qc qb stays 000. clkb held 1 -> qb/qc/qd increment every edge (000 -> 001 -> ... -> 111 -> 000 after 8 edges).
- SN74LS93_TC_EN defined: tc = 1 only at count 1111. tc = 0 after wrap and during clear.
